// File: rtl/e203_ifu_bht_pkg.sv
// Shared BHT definitions: 2-bit counter encodings, saturating update and the
// table index function used by the BHT, EXU-side logic and checkers alike.
package e203_ifu_bht_pkg;

  typedef enum logic [1:0] {
    CNT_SNT = 2'b00,
    CNT_WNT = 2'b01,
    CNT_WT  = 2'b10,
    CNT_ST  = 2'b11
  } bht_cnt_e;

  localparam logic [1:0] CNT_RST = CNT_WNT;

  function automatic logic [1:0] cnt_sat(input logic [1:0] cnt, input logic taken);
    logic [1:0] nxt;
    nxt = cnt;
    if (taken && (cnt != CNT_ST)) begin
      nxt = cnt + 2'd1;
    end else if (!taken && (cnt != CNT_SNT)) begin
      nxt = cnt - 2'd1;
    end
    return nxt;
  endfunction

  // Caller truncates to idx_w bits: the low bits are pc[idx_w:1] XOR the
  // history left-aligned into the index field (zero-padded below).
  function automatic logic [31:0] bht_idx(input logic [31:0] pc, input logic [31:0] ghr,
                                          input int idx_w, input int hist_w);
    return (pc >> 1) ^ (ghr << (idx_w - hist_w));
  endfunction

endpackage

// File: rtl/e203_ifu_bht_if.sv
// IFU lookup / EXU writeback / flush bundle of the branch history table.
interface e203_ifu_bht_if #(
  parameter int PC_SIZE   = 32,
  parameter int MIS_CNT_W = 16
);
  logic                 lkup_vld;
  logic [PC_SIZE-1:0]   lkup_pc;
  logic                 prdt_taken;
  logic                 bht_ready;
  logic                 upd_vld;
  logic [PC_SIZE-1:0]   upd_pc;
  logic                 upd_taken;
  logic                 upd_mis;
  logic                 flush_req;
  logic [MIS_CNT_W-1:0] mis_cnt;

  modport master (
    output lkup_vld, lkup_pc, upd_vld, upd_pc, upd_taken, upd_mis, flush_req,
    input  prdt_taken, bht_ready, mis_cnt
  );

  modport slave (
    input  lkup_vld, lkup_pc, upd_vld, upd_pc, upd_taken, upd_mis, flush_req,
    output prdt_taken, bht_ready, mis_cnt
  );
endinterface

// File: rtl/e203_ifu_bht_cnt2.sv
// One BHT entry: 2-bit saturating counter with synchronous re-init.
module e203_ifu_bht_cnt2
  import e203_ifu_bht_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       init_i,
  input  logic       we_i,
  input  logic       taken_i,
  output logic [1:0] cnt_o
);

  logic [1:0] cnt_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= CNT_RST;
    end else if (init_i) begin
      cnt_q <= CNT_RST;
    end else if (we_i) begin
      cnt_q <= cnt_sat(cnt_q, taken_i);
    end
  end

  assign cnt_o = cnt_q;

endmodule

// File: rtl/e203_ifu_bht.sv
// Branch history table for the IFU lite predictor: combinational lookup,
// one-cycle registered training, optional gshare history and mispredict count.
module e203_ifu_bht
  import e203_ifu_bht_pkg::*;
#(
  parameter int PC_SIZE   = 32,
  parameter int IDX_W     = 4,
  parameter int HIST_W    = 4,
  parameter int MIS_CNT_W = 16
) (
  input  logic              clk,
  input  logic              rst,
  e203_ifu_bht_if.slave     bht_if
);

  localparam int ENTRIES = 1 << IDX_W;
  localparam int GHR_W   = (HIST_W > 0) ? HIST_W : 1;

  logic [GHR_W-1:0]     ghr_q, ghr_d;
  logic                 u_vld_q, u_taken_q, u_mis_q;
  logic [IDX_W-1:0]     u_idx_q;
  logic [MIS_CNT_W-1:0] mis_cnt_q;
  logic                 flush_dly_q;

  logic [IDX_W-1:0]     upd_idx, lk_idx;
  logic [1:0]           cnt_w [ENTRIES];
  logic [1:0]           u_post, lk_cnt;
  logic                 ready;

  assign upd_idx = IDX_W'(bht_idx(32'(bht_if.upd_pc), 32'(ghr_q), IDX_W, HIST_W));
  assign lk_idx  = IDX_W'(bht_idx(32'(bht_if.lkup_pc), 32'(ghr_q), IDX_W, HIST_W));

  generate
    if (HIST_W > 0) begin : g_ghr
      assign ghr_d = GHR_W'({ghr_q, u_taken_q});
    end else begin : g_no_ghr
      assign ghr_d = '0;
    end
  endgenerate

  // Flush outranks everything, including a writeback arriving the same cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ghr_q       <= '0;
      u_vld_q     <= 1'b0;
      u_idx_q     <= '0;
      u_taken_q   <= 1'b0;
      u_mis_q     <= 1'b0;
      mis_cnt_q   <= '0;
      flush_dly_q <= 1'b0;
    end else begin
      flush_dly_q <= bht_if.flush_req;
      if (bht_if.flush_req) begin
        u_vld_q   <= 1'b0;
        ghr_q     <= '0;
        mis_cnt_q <= '0;
      end else begin
        u_vld_q <= bht_if.upd_vld;
        if (bht_if.upd_vld) begin
          u_idx_q   <= upd_idx;
          u_taken_q <= bht_if.upd_taken;
          u_mis_q   <= bht_if.upd_mis;
        end
        if (u_vld_q) begin
          ghr_q <= ghr_d;
          if (u_mis_q && (mis_cnt_q != '1)) begin
            mis_cnt_q <= mis_cnt_q + MIS_CNT_W'(1);
          end
        end
      end
    end
  end

  // Each entry re-reads its own value at write time, so back-to-back updates
  // to one index chain naturally.
  generate
    for (genvar gi = 0; gi < ENTRIES; gi++) begin : g_cnt
      e203_ifu_bht_cnt2 u_cnt (
        .clk     (clk),
        .rst     (rst),
        .init_i  (bht_if.flush_req),
        .we_i    (u_vld_q && (u_idx_q == IDX_W'(gi))),
        .taken_i (u_taken_q),
        .cnt_o   (cnt_w[gi])
      );
    end
  endgenerate

  assign u_post = cnt_sat(cnt_w[u_idx_q], u_taken_q);
  assign lk_cnt = (u_vld_q && (lk_idx == u_idx_q)) ? u_post : cnt_w[lk_idx];
  assign ready  = ~(bht_if.flush_req | flush_dly_q);

  assign bht_if.prdt_taken = bht_if.lkup_vld & ready & lk_cnt[1];
  assign bht_if.bht_ready  = ready;
  assign bht_if.mis_cnt    = mis_cnt_q;

endmodule
